switch_credit_arbiter: RTL and testbench

Per-output-port switch allocator with downstream credit tracking for the virtual-channel router. Each cycle, for every output port, it picks one requesting input port by round-robin. An input is eligible only if the downstream VC it targets has a free buffer slot. It issues registered one-hot grants to the buffer-read/switch-traversal stages and keeps a credit counter per downstream VC.

---
 rtl/switch_credit_arbiter.sv | 161 ++++++++++++++++
 tb/tb_switch_credit_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_credit_arbiter.sv
// switch_credit_arbiter: per-output round-robin switch allocator with
// downstream credit tracking. Grants are registered and one-hot per output;
// an input is eligible only if its target downstream VC has a free slot.
module switch_credit_arbiter #(
  parameter int NUM_PORTS   = 5,
  parameter int NUM_VC      = 4,
  parameter int BUF_DEPTH   = 4,
  parameter int VC_BITS     = $clog2(NUM_VC),
  parameter int CREDIT_BITS = $clog2(BUF_DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS-1:0][VC_BITS-1:0]     req_vc,
  input  logic [NUM_PORTS-2:0]                  credit_return,
  input  logic [NUM_PORTS-2:0][VC_BITS-1:0]     credit_return_vc,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   gnt,
  output logic [NUM_PORTS-1:0]                  gnt_valid,
  output logic [NUM_PORTS-2:0][NUM_VC-1:0]      credit_avail,
  output logic                                  credit_err
);

  localparam int PORT_BITS = $clog2(NUM_PORTS);
  localparam int SUM_BITS  = PORT_BITS + 1;
  localparam int NUM_NET   = NUM_PORTS - 1;

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]             req_clean;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]             elig;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]             gnt_next;
  logic [NUM_PORTS-1:0][PORT_BITS-1:0]             winner;
  logic [NUM_PORTS-1:0]                            found;
  logic [NUM_PORTS-1:0][PORT_BITS-1:0]             rr_ptr;
  logic [NUM_NET-1:0][NUM_VC-1:0][CREDIT_BITS-1:0] credits;
  logic [NUM_NET-1:0][NUM_VC-1:0]                  dec;
  logic [NUM_NET-1:0][NUM_VC-1:0]                  inc;
  logic                                            overflow;
  logic [SUM_BITS-1:0]                             scan_sum;
  logic [PORT_BITS-1:0]                            scan_idx;

  // Keep only the lowest requested output of each input (x & -x).
  always_comb begin
    req_clean = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_clean[i] = req[i] & (~req[i] + NUM_PORTS'(1));
    end
  end

  // Eligibility: network outputs need a nonzero pre-edge credit count, local never does.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int o = 0; o < NUM_NET; o++) begin
        elig[o][i] = req_clean[i][o] && (credits[o][req_vc[i]] != '0);
      end
      elig[NUM_NET][i] = req_clean[i][NUM_NET];
    end
  end

  // Round-robin scan per output, starting at rr_ptr and wrapping modulo NUM_PORTS.
  always_comb begin
    gnt_next = '0;
    winner   = '0;
    found    = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        scan_sum = {1'b0, rr_ptr[o]} + SUM_BITS'(k);
        if (scan_sum >= SUM_BITS'(NUM_PORTS)) begin
          scan_sum = scan_sum - SUM_BITS'(NUM_PORTS);
        end
        scan_idx = scan_sum[PORT_BITS-1:0];
        if (!found[o] && elig[o][scan_idx]) begin
          found[o]              = 1'b1;
          winner[o]             = scan_idx;
          gnt_next[o][scan_idx] = 1'b1;
        end
      end
    end
  end

  // Credit consume/return events per downstream VC, plus full-counter overflow detection.
  always_comb begin
    dec      = '0;
    inc      = '0;
    overflow = 1'b0;
    for (int o = 0; o < NUM_NET; o++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (gnt_next[o][i] && (req_vc[i] == VC_BITS'(v))) begin
            dec[o][v] = 1'b1;
          end
        end
        inc[o][v] = credit_return[o] && (credit_return_vc[o] == VC_BITS'(v));
        if (inc[o][v] && !dec[o][v] && (credits[o][v] == CREDIT_BITS'(BUF_DEPTH))) begin
          overflow = 1'b1;
        end
      end
    end
  end

  // Register the grants and advance each pointer past its winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      gnt <= gnt_next;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (found[o]) begin
          if (winner[o] == PORT_BITS'(NUM_PORTS - 1)) begin
            rr_ptr[o] <= '0;
          end else begin
            rr_ptr[o] <= winner[o] + PORT_BITS'(1);
          end
        end
      end
    end
  end

  // Credit counters and sticky overflow flag; a return to a full counter is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NUM_NET; o++) begin
        for (int v = 0; v < NUM_VC; v++) begin
          credits[o][v] <= CREDIT_BITS'(BUF_DEPTH);
        end
      end
      credit_err <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_NET; o++) begin
        for (int v = 0; v < NUM_VC; v++) begin
          if (dec[o][v] && !inc[o][v]) begin
            credits[o][v] <= credits[o][v] - CREDIT_BITS'(1);
          end else if (inc[o][v] && !dec[o][v] &&
                       (credits[o][v] != CREDIT_BITS'(BUF_DEPTH))) begin
            credits[o][v] <= credits[o][v] + CREDIT_BITS'(1);
          end
        end
      end
      if (overflow) begin
        credit_err <= 1'b1;
      end
    end
  end

  // Output flags derived directly from registered grant and credit state.
  always_comb begin
    gnt_valid    = '0;
    credit_avail = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_valid[o] = |gnt[o];
    end
    for (int o = 0; o < NUM_NET; o++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        credit_avail[o][v] = (credits[o][v] != '0);
      end
    end
  end

endmodule

// File: tb/tb_switch_credit_arbiter.sv
// tb_switch_credit_arbiter: directed vectors with hand-computed expectations
// pushed into a scoreboard queue; a monitor pops and compares each cycle.
module tb_switch_credit_arbiter;

  typedef logic [4:0][4:0] req_t;
  typedef logic [4:0][1:0] vc_t;
  typedef logic [3:0]      cr_t;
  typedef logic [3:0][1:0] crvc_t;
  typedef logic [3:0][3:0] avail_t;

  typedef struct packed {
    req_t   g;
    avail_t a;
    logic   e;
  } exp_t;

  logic   clk;
  logic   reset;
  req_t   req;
  vc_t    req_vc;
  cr_t    credit_return;
  crvc_t  credit_return_vc;
  req_t   gnt;
  logic [4:0] gnt_valid;
  avail_t credit_avail;
  logic   credit_err;

  exp_t   sb_q[$];
  int     checks;
  int     errors;

  req_t   r;
  vc_t    rv;
  crvc_t  cv;
  int     rr_seq [6];

  switch_credit_arbiter #(
    .NUM_PORTS(5),
    .NUM_VC(4),
    .BUF_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_vc(req_vc),
    .credit_return(credit_return),
    .credit_return_vc(credit_return_vc),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .credit_avail(credit_avail),
    .credit_err(credit_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic req_t bit2(input int a, input int b);
    req_t t;
    t = '0;
    t[a][b] = 1'b1;
    return t;
  endfunction

  function automatic avail_t av_clr(input int o, input int v);
    avail_t t;
    t = '1;
    t[o][v] = 1'b0;
    return t;
  endfunction

  function automatic logic [4:0] vld(input req_t g);
    logic [4:0] t;
    for (int o = 0; o < 5; o++) t[o] = |g[o];
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input req_t rq, input vc_t rvc, input cr_t cr, input crvc_t crv,
                               input req_t eg, input avail_t ea, input logic ee);
    exp_t e;
    @(negedge clk);
    req              = rq;
    req_vc           = rvc;
    credit_return    = cr;
    credit_return_vc = crv;
    e.g = eg;
    e.a = ea;
    e.e = ee;
    sb_q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare DUT outputs against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checkOutput("gnt", 32'(gnt), 32'(e.g));
          checkOutput("gnt_valid", 32'(gnt_valid), 32'(vld(e.g)));
          checkOutput("credit_avail", 32'(credit_avail), 32'(e.a));
          checkOutput("credit_err", 32'(credit_err), 32'(e.e));
        end else if (gnt_valid != 5'b0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_grant: got %h expected 00 at %0t", gnt_valid, $time);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int wait_cnt;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    req = '0;
    req_vc = '0;
    credit_return = '0;
    credit_return_vc = '0;

    // Reset held with random activity on inputs.
    repeat (3) begin
      @(negedge clk);
      req              = req_t'($urandom);
      req_vc           = vc_t'($urandom);
      credit_return    = cr_t'($urandom);
      credit_return_vc = crvc_t'($urandom);
    end
    @(negedge clk);
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_gnt_valid", 32'(gnt_valid), 32'h0);
    checkOutput("rst_credit_err", 32'(credit_err), 32'h0);
    checkOutput("rst_credit_avail", 32'(credit_avail), 32'hFFFF);
    req = '0;
    credit_return = '0;
    reset = 1'b1;

    // First grant after reset: input 2 -> output 1, VC0.
    applyStimulus(bit2(2, 1), '0, '0, '0, bit2(1, 2), '1, 1'b0);
    applyStimulus('0, '0, '0, '0, '0, '1, 1'b0);

    // Round-robin on output 0 among inputs 0, 1, 3 (VCs 0, 1, 2).
    r = bit2(0, 0) | bit2(1, 0) | bit2(3, 0);
    rv = '0;
    rv[1] = 2'd1;
    rv[3] = 2'd2;
    rr_seq = '{0, 1, 3, 0, 1, 3};
    for (int k = 0; k < 6; k++) begin
      applyStimulus(r, rv, '0, '0, bit2(0, rr_seq[k]), '1, 1'b0);
    end
    applyStimulus('0, '0, '0, '0, '0, '1, 1'b0);

    // Credit exhaustion: input 4 -> output 2, VC1.
    r = bit2(4, 2);
    rv = '0;
    rv[4] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(r, rv, '0, '0, bit2(2, 4), (k == 3) ? av_clr(2, 1) : '1, 1'b0);
    end
    applyStimulus(r, rv, '0, '0, '0, av_clr(2, 1), 1'b0);
    applyStimulus(r, rv, '0, '0, '0, av_clr(2, 1), 1'b0);
    cv = '0;
    cv[2] = 2'd1;
    applyStimulus(r, rv, 4'b0100, cv, '0, '1, 1'b0);
    applyStimulus(r, rv, '0, '0, bit2(2, 4), av_clr(2, 1), 1'b0);
    applyStimulus(r, rv, '0, '0, '0, av_clr(2, 1), 1'b0);
    applyStimulus('0, '0, 4'b0100, cv, '0, '1, 1'b0);

    // Simultaneous grant and return on output 3 VC2 at count 1.
    r = bit2(0, 3);
    rv = '0;
    rv[0] = 2'd2;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(r, rv, '0, '0, bit2(3, 0), '1, 1'b0);
    end
    cv = '0;
    cv[3] = 2'd2;
    applyStimulus(r, rv, 4'b1000, cv, bit2(3, 0), '1, 1'b0);
    applyStimulus(r, rv, '0, '0, bit2(3, 0), av_clr(3, 2), 1'b0);
    applyStimulus('0, '0, 4'b1000, cv, '0, '1, 1'b0);

    // Local output 4 requested by all inputs for 20 cycles.
    r = '0;
    rv = '0;
    for (int i = 0; i < 5; i++) begin
      r[i][4] = 1'b1;
      rv[i] = 2'(i);
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(r, rv, '0, '0, bit2(4, k % 5), '1, 1'b0);
    end

    // Multi-hot request on input 1 uses only output 1; input 0 takes output 4.
    r = '0;
    r[1] = 5'b10010;
    r[0] = 5'b10000;
    applyStimulus(r, '0, '0, '0, bit2(1, 1) | bit2(4, 0), '1, 1'b0);
    applyStimulus('0, '0, '0, '0, '0, '1, 1'b0);

    // Overflow: output 0 VC0 sits at 2, refill to 4, then one extra return.
    applyStimulus('0, '0, 4'b0001, '0, '0, '1, 1'b0);
    applyStimulus('0, '0, 4'b0001, '0, '0, '1, 1'b0);
    applyStimulus('0, '0, 4'b0001, '0, '0, '1, 1'b1);
    applyStimulus('0, '0, '0, '0, '0, '1, 1'b1);

    // Mid-operation reset during an active grant (input 2 -> output 0, VC3).
    r = bit2(2, 0);
    rv = '0;
    rv[2] = 2'd3;
    applyStimulus(r, rv, '0, '0, bit2(0, 2), '1, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("midrst_gnt", 32'(gnt), 32'h0);
    checkOutput("midrst_gnt_valid", 32'(gnt_valid), 32'h0);
    checkOutput("midrst_credit_err", 32'(credit_err), 32'h0);
    checkOutput("midrst_credit_avail", 32'(credit_avail), 32'hFFFF);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    reset = 1'b1;

    // Counters restored to 4: exactly four grants before exhaustion.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(r, rv, '0, '0, bit2(0, 2), (k == 3) ? av_clr(0, 3) : '1, 1'b0);
    end
    applyStimulus(r, rv, '0, '0, '0, av_clr(0, 3), 1'b0);
    applyStimulus('0, '0, '0, '0, '0, av_clr(0, 3), 1'b0);

    // Drain the scoreboard with a bounded wait.
    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
